// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: RAW hazard stalls, branch flushes and memory wait stalls for a 5-stage core.
// Define PIPE_FORWARDING_EN when an EXE forwarding unit exists; only load-use then stalls.
module pipeline_ctrl #(
    parameter int unsigned REG_W       = 4,
    parameter int unsigned MEM_LATENCY = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_use_src1,
    input  logic             exe_wb_en,
    input  logic             exe_mem_rd,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    output logic             hazard_stall,
    output logic             flush,
    output logic             mem_stall,
    output logic             mem_ready,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned      WcntW    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [REG_W-1:0] PcReg    = REG_W'(15);
    localparam logic [WcntW-1:0] WcntInit = WcntW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    typedef enum logic [0:0] {StRun, StWait} state_e;

    state_e           stateQ, stateD;
    logic [WcntW-1:0] wcntQ, wcntD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             memStall, memReady;
    logic             src1Hit, src2Hit, raw;
    logic             flushInt, hazardInt;

`ifdef PIPE_FORWARDING_EN
    assign src1Hit = exe_wb_en & exe_mem_rd & (id_src1 == exe_dest);
    assign src2Hit = exe_wb_en & exe_mem_rd & (id_src2 == exe_dest);
`else
    assign src1Hit = (exe_wb_en & (id_src1 == exe_dest)) | (mem_wb_en & (id_src1 == mem_dest));
    assign src2Hit = (exe_wb_en & (id_src2 == exe_dest)) | (mem_wb_en & (id_src2 == mem_dest));
`endif

    // PC reads are served from the fetch path, so r15 never creates a hazard
    assign raw = (id_use_src1 & src1Hit & (id_src1 != PcReg))
               | (id_two_src  & src2Hit & (id_src2 != PcReg));

    always_comb begin
        stateD   = stateQ;
        wcntD    = wcntQ;
        memStall = 1'b0;
        memReady = 1'b0;
        unique case (stateQ)
            StRun: begin
                if (mem_req) begin
                    if (MEM_LATENCY == 1) begin
                        memReady = 1'b1;
                    end else begin
                        memStall = 1'b1;
                        wcntD    = WcntInit;
                        stateD   = StWait;
                    end
                end
            end
            StWait: begin
                if (wcntQ != '0) begin
                    memStall = 1'b1;
                    wcntD    = wcntQ - WcntW'(1);
                end else begin
                    memReady = 1'b1;
                    stateD   = StRun;
                end
            end
            default: stateD = StRun;
        endcase
    end

    // A branch seen while memory is waiting is held in EXE and flushes on the ready cycle
    assign flushInt  = branch_taken & ~memStall;
    assign hazardInt = raw & ~branch_taken & ~memStall;

    always_comb begin
        cntD = cntQ;
        if ((memStall | hazardInt) && (cntQ != '1)) begin
            cntD = cntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StRun;
            wcntQ  <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            wcntQ  <= wcntD;
            cntQ   <= cntD;
        end
    end

    assign mem_stall    = rst & memStall;
    assign mem_ready    = rst & memReady;
    assign flush        = rst & flushInt;
    assign hazard_stall = rst & hazardInt;
    assign stall_cycles = rst ? cntQ : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: per-cycle model comparison plus directed literal checks.
// A narrow stall counter is used so saturation is reachable quickly.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W       = 4;
    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          Lat         = int'(MEM_LATENCY);
    localparam int          CntMax      = (1 << CNT_W) - 1;

`ifdef PIPE_FORWARDING_EN
    localparam int Fwd = 1;
`else
    localparam int Fwd = 0;
`endif

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
    logic             id_two_src, id_use_src1, exe_wb_en, exe_mem_rd, mem_wb_en;
    logic             branch_taken, mem_req;
    logic             hazard_stall, flush, mem_stall, mem_ready;
    logic [CNT_W-1:0] stall_cycles;

    int nVec  = 0;
    int nFail = 0;

    pipeline_ctrl #(
        .REG_W      (REG_W),
        .MEM_LATENCY(MEM_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .id_use_src1 (id_use_src1),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_rd  (exe_mem_rd),
        .exe_dest    (exe_dest),
        .mem_wb_en   (mem_wb_en),
        .mem_dest    (mem_dest),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .hazard_stall(hazard_stall),
        .flush       (flush),
        .mem_stall   (mem_stall),
        .mem_ready   (mem_ready),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit regMatch(input logic [REG_W-1:0] r);
        if (r == 15) return 1'b0;
        if (Fwd != 0) return exe_wb_en && exe_mem_rd && (r == exe_dest);
        return (exe_wb_en && (r == exe_dest)) || (mem_wb_en && (r == mem_dest));
    endfunction

    // Model: position within the current memory access (-1 = none), and stall count
    int busy   = -1;
    int expCnt = 0;

    always @(negedge clk) begin
        int idx;
        bit eStall, eReady, eFlush, eHaz;
        eStall = 0; eReady = 0; eFlush = 0; eHaz = 0;
        if (!rst) begin
            busy   = -1;
            expCnt = 0;
        end else begin
            idx    = (busy >= 0) ? busy : (mem_req ? 0 : -1);
            eStall = (idx >= 0) && (idx < Lat - 1);
            eReady = (idx == Lat - 1);
            busy   = (idx < 0 || eReady) ? -1 : idx + 1;
            eFlush = branch_taken && !eStall;
            eHaz   = ((id_use_src1 && regMatch(id_src1)) || (id_two_src && regMatch(id_src2)))
                     && !branch_taken && !eStall;
        end
        check("model.mem_stall", int'(mem_stall), int'(eStall));
        check("model.mem_ready", int'(mem_ready), int'(eReady));
        check("model.flush", int'(flush), int'(eFlush));
        check("model.hazard_stall", int'(hazard_stall), int'(eHaz));
        check("model.stall_cycles", int'(stall_cycles), expCnt);
        if (rst && (eStall || eHaz) && expCnt < CntMax) expCnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clearIn();
        id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
        id_two_src = 0; id_use_src1 = 0; exe_wb_en = 0; exe_mem_rd = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0;
    endtask

    task automatic loadUse(input logic [REG_W-1:0] r);
        id_use_src1 = 1; id_src1 = r; exe_wb_en = 1; exe_mem_rd = 1; exe_dest = r;
    endtask

    initial begin
        rst = 1'b0;
        clearIn();
        repeat (3) step();
        sample();
        check("reset.mem_stall", int'(mem_stall), 0);
        check("reset.stall_cycles", int'(stall_cycles), 0);

        // Idle after release
        step();
        rst = 1'b1;
        repeat (20) step();
        sample();
        check("idle.mem_stall", int'(mem_stall), 0);
        check("idle.mem_ready", int'(mem_ready), 0);
        check("idle.flush", int'(flush), 0);
        check("idle.hazard_stall", int'(hazard_stall), 0);
        check("idle.stall_cycles", int'(stall_cycles), 0);

        // Single access, request held one cycle
        step(); mem_req = 1; sample(); check("mem.c1_stall", int'(mem_stall), 1);
        step(); mem_req = 0; sample(); check("mem.c2_stall", int'(mem_stall), 1);
        step(); sample(); check("mem.c3_stall", int'(mem_stall), 1);
        step(); sample();
        check("mem.c4_stall", int'(mem_stall), 0);
        check("mem.c4_ready", int'(mem_ready), 1);
        step(); sample();
        check("mem.after_ready", int'(mem_ready), 0);
        check("mem.stall_cycles", int'(stall_cycles), 3);

        // RAW against a non-load EXE writer
        step();
        id_src1 = 3; id_use_src1 = 1; exe_wb_en = 1; exe_dest = 3; exe_mem_rd = 0;
        sample(); check("raw.exe_alu", int'(hazard_stall), (Fwd != 0) ? 0 : 1);
        step(); exe_mem_rd = 1;
        sample(); check("raw.exe_load", int'(hazard_stall), 1);
        step(); clearIn();
        id_two_src = 1; id_src2 = 7; mem_wb_en = 1; mem_dest = 7;
        sample(); check("raw.mem_src2", int'(hazard_stall), (Fwd != 0) ? 0 : 1);
        step(); clearIn();
        loadUse(4'd15); id_two_src = 1; id_src2 = 15; mem_wb_en = 1; mem_dest = 15;
        sample(); check("raw.pc_ignored", int'(hazard_stall), 0);

        // Branch beats RAW
        step(); clearIn(); loadUse(4'd3); branch_taken = 1;
        sample();
        check("branch.flush", int'(flush), 1);
        check("branch.hazard_stall", int'(hazard_stall), 0);

        // Branch held across a memory wait flushes only on the ready cycle
        step(); clearIn(); mem_req = 1; branch_taken = 1;
        sample(); check("bwait.c1_flush", int'(flush), 0);
        step(); mem_req = 0;
        sample(); check("bwait.c2_flush", int'(flush), 0);
        step(); sample(); check("bwait.c3_flush", int'(flush), 0);
        step(); sample();
        check("bwait.c4_flush", int'(flush), 1);
        check("bwait.c4_ready", int'(mem_ready), 1);

        // Reset in the middle of a wait
        step(); clearIn(); mem_req = 1;
        sample();
        step(); mem_req = 0; branch_taken = 1; loadUse(4'd5);
        sample(); check("rstwait.pre_stall", int'(mem_stall), 1);
        step(); rst = 1'b0;
        #1;
        check("rstwait.mem_stall", int'(mem_stall), 0);
        check("rstwait.flush", int'(flush), 0);
        check("rstwait.hazard_stall", int'(hazard_stall), 0);
        check("rstwait.stall_cycles", int'(stall_cycles), 0);
        sample();
        step(); rst = 1'b1; clearIn();
        for (int i = 0; i < 6; i++) begin
            sample();
            check("rstwait.no_ready", int'(mem_ready), 0);
            check("rstwait.no_stall", int'(mem_stall), 0);
        end

        // Counter saturation under a held load-use stall
        step(); loadUse(4'd2);
        repeat (20) step();
        sample();
        check("sat.hazard_stall", int'(hazard_stall), 1);
        check("sat.stall_cycles", int'(stall_cycles), CntMax);
        step(); clearIn();
        repeat (3) step();
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
